// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the game timers: state encoding and default widths.
// The up-counter imports the same package, so DEFAULT_WIDTH stays in step between the two blocks.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH     = 28;
  localparam int DEFAULT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the game FSM (master) and the countdown timer (slave).
// Semantics: start/clear/pause are levels sampled on every clock edge, with no valid/ready handshake.
// load_value and auto_reload matter only on an edge where start is high.
// All status outputs are registered and valid one edge after the event that caused them.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

  logic                 start;
  logic                 clear;
  logic                 pause;
  logic                 auto_reload;
  logic [WIDTH-1:0]     load_value;
  logic [WIDTH-1:0]     remaining;
  logic                 busy;
  logic                 paused;
  logic                 timed_out;
  logic                 expired;
  logic [CNT_WIDTH-1:0] expire_count;
  state_e               state;

  modport master (
    output start, clear, pause, auto_reload, load_value,
    input  remaining, busy, paused, timed_out, expired, expire_count, state
  );

  modport slave (
    input  start, clear, pause, auto_reload, load_value,
    output remaining, busy, paused, timed_out, expired, expire_count, state
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer: counts a duration in clock_50 cycles, then reports expiry as a
// one-cycle pulse, a sticky level in DONE and a saturating expiry count. It can reload itself.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic               clock_50,
  input  logic               reset,
  countdown_timer_if.slave   tmr
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     remaining_q, remaining_d;
  logic [WIDTH-1:0]     reload_val_q, reload_val_d;
  logic                 reload_en_q, reload_en_d;
  logic                 expired_q, expired_d;
  logic [CNT_WIDTH-1:0] expire_count_q, expire_count_d;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 busy_q, paused_q, timed_out_q;

  // Expiry counter sticks at all-ones rather than wrapping.
  always_comb begin
    count_inc = expire_count_q;
    if (expire_count_q != {CNT_WIDTH{1'b1}}) begin
      count_inc = expire_count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    reload_val_d   = reload_val_q;
    reload_en_d    = reload_en_q;
    expired_d      = 1'b0;
    expire_count_d = expire_count_q;

    if (tmr.clear) begin
      state_d        = ST_IDLE;
      remaining_d    = '0;
      expire_count_d = '0;
    end else if (tmr.start) begin
      reload_val_d = tmr.load_value;
      reload_en_d  = tmr.auto_reload;
      if (tmr.load_value == '0) begin
        // A zero duration expires immediately and always parks in DONE, so reload cannot spin.
        state_d        = ST_DONE;
        remaining_d    = '0;
        expired_d      = 1'b1;
        expire_count_d = count_inc;
      end else begin
        state_d     = ST_RUN;
        remaining_d = tmr.load_value;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tmr.pause) begin
            state_d = ST_PAUSED;
          end else if (remaining_q > WIDTH'(1)) begin
            remaining_d = remaining_q - WIDTH'(1);
          end else begin
            expired_d      = 1'b1;
            expire_count_d = count_inc;
            if (reload_en_q) begin
              remaining_d = reload_val_q;
            end else begin
              remaining_d = '0;
              state_d     = ST_DONE;
            end
          end
        end
        // The resume edge does not decrement; counting picks up on the following edge.
        ST_PAUSED: begin
          if (!tmr.pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          remaining_d = '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      reload_val_q   <= '0;
      reload_en_q    <= 1'b0;
      expired_q      <= 1'b0;
      expire_count_q <= '0;
      busy_q         <= 1'b0;
      paused_q       <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      reload_val_q   <= reload_val_d;
      reload_en_q    <= reload_en_d;
      expired_q      <= expired_d;
      expire_count_q <= expire_count_d;
      busy_q         <= state_is_busy(state_d);
      paused_q       <= (state_d == ST_PAUSED);
      timed_out_q    <= (state_d == ST_DONE);
    end
  end

  assign tmr.remaining    = remaining_q;
  assign tmr.busy         = busy_q;
  assign tmr.paused       = paused_q;
  assign tmr.timed_out    = timed_out_q;
  assign tmr.expired      = expired_q;
  assign tmr.expire_count = expire_count_q;
  assign tmr.state        = state_q;

endmodule
